// File: rtl/oh_arb_pkg.sv
// oh_arb_pkg
// Shared definitions for the three-requester packet arbiter.
//   N         : number of requesters served by the arbiter
//   state_t   : arbiter FSM state (IDLE = 0, BUSY = 1)
//   next_ptr  : round-robin pointer that follows a given one-hot winner
package oh_arb_pkg;

    localparam int N = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The requester after the winner gets top priority next time,
    // so the packet owner drops to lowest priority.
    function automatic logic [1:0] next_ptr(input logic [N-1:0] onehot);
        logic [1:0] p;
        p = 2'd0;
        if (onehot[0]) p = 2'd1;
        if (onehot[1]) p = 2'd2;
        if (onehot[2]) p = 2'd0;
        return p;
    endfunction

endpackage

// File: rtl/oh_rrpick3.sv
// oh_rrpick3
// Purely combinational round-robin picker for three requesters.
//   req : request vector, bit i = requester i
//   ptr : requester with highest priority (0..2); then ptr+1, ptr+2 mod 3
//   win : one-hot winner, all zero when no request is present
module oh_rrpick3
    import oh_arb_pkg::*;
(
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] win
);

    // Rotated priority search starting at ptr; a pointer value of 3
    // never occurs in practice and is treated like 0.
    always_comb begin
        win = '0;
        case (ptr)
            2'd1: begin
                if      (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
            end
            2'd2: begin
                if      (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
            end
            default: begin
                if      (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/oh_arb3_rr.sv
// oh_arb3_rr
// Packet-locked round-robin arbiter merging three beat streams into one
// registered output channel.
//   clk, reset        : single clock, synchronous active-high reset
//   in_valid/in_last  : per-requester beat valid and end-of-packet flag
//   in_data           : packed beats, requester i at [i*DW +: DW]
//   in_ready          : per-requester accept (only the owner, only in BUSY)
//   out_valid/out_data/out_last : registered output beat
//   out_ready         : downstream accept
//   grant             : one-hot packet owner, zero when idle
//   busy              : high while a packet is locked
module oh_arb3_rr
    import oh_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic [N-1:0]    grant,
    output logic            busy
);

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [N-1:0]  win;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          out_last_q;
    logic [DW-1:0] sel_data;
    logic          sel_last;
    logic          accept;

    oh_rrpick3 u_pick (
        .req (in_valid),
        .ptr (ptr_q),
        .win (win)
    );

    // One-hot AND-OR select of the owner's beat; grant is one-hot so no
    // priority is needed in the datapath.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | (in_data[i*DW +: DW] & {DW{grant_q[i]}});
            sel_last = sel_last | (in_last[i] & grant_q[i]);
        end
    end

    // The owner may push a beat when the output register is empty or is
    // being drained this cycle; nothing is accepted while arbitrating.
    always_comb begin
        in_ready = '0;
        if (state_q == BUSY)
            in_ready = grant_q & {N{~out_valid_q | out_ready}};
    end

    assign accept = |(in_valid & in_ready);

    // Next-state logic: arbitrate in IDLE, stay locked in BUSY until the
    // owner's last beat is taken, then rotate the pointer past the owner.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|in_valid) begin
                    grant_d = win;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    grant_d = '0;
                    ptr_d   = next_ptr(grant_q);
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State register for the FSM, owner and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Output register: loads on accept, empties when drained without a
    // replacement, and holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_last_q  <= sel_last;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign grant     = grant_q;
    assign busy      = (state_q == BUSY);

endmodule
